// File: rtl/clock_alarm_fsm.sv
// rtl/clock_alarm_fsm.sv - HH:MM:SS clock with set/inc button FSM, seconds LED bar and timed alarm
// Alarm registers, match and ring counter are built only when CLOCK_ALARM_EN is defined.
module clock_alarm_fsm #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int LED_N     = 10,
  parameter int ALARM_LEN = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             inc,
  input  logic             dn,
  input  logic             alm_sel,
  input  logic             alm_en,
  input  logic             ack,
  output logic [1:0]       hr_tens,
  output logic [3:0]       hr_ones,
  output logic [2:0]       min_tens,
  output logic [3:0]       min_ones,
  output logic [5:0]       sec,
  output logic [1:0]       mode,
  output logic [LED_N-1:0] leds,
  output logic             alarm
);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [1:0] S_IDLE     = 2'b00;
  localparam logic [1:0] S_SET_HOUR = 2'b01;
  localparam logic [1:0] S_SET_MIN  = 2'b10;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             set_q, inc_q;
  logic [1:0]       mode_q, mode_d;
  logic [5:0]       hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic [1:0]       hr_tens_q, hr_tens_d;
  logic [3:0]       hr_ones_q, hr_ones_d;
  logic [2:0]       min_tens_q, min_tens_d;
  logic [3:0]       min_ones_q, min_ones_d;
  logic [LED_N-1:0] leds_q, leds_d;
  logic             set_ev, inc_ev, tick, time_run, alm_sel_eff;
  logic [5:0]       disp_hr, disp_min;
  int               led_k;

  function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] top, input logic down);
    if (down) return (v == 6'd0) ? top : v - 6'd1;
    return (v == top) ? 6'd0 : v + 6'd1;
  endfunction

  always_comb begin
    set_ev   = set & ~set_q;
    inc_ev   = inc & ~inc_q;
    tick     = (pre_q == PRE_W'(TICK_DIV - 1));
    time_run = (mode_q == S_IDLE) || alm_sel_eff;
    pre_d    = tick ? '0 : pre_q + PRE_W'(1);

    mode_d = mode_q;
    case (mode_q)
      S_IDLE:     if (set_ev) mode_d = S_SET_HOUR;
      S_SET_HOUR: if (set_ev) mode_d = S_SET_MIN;
      S_SET_MIN:  if (set_ev) mode_d = S_IDLE;
      default:    mode_d = S_IDLE;
    endcase

    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (tick && time_run) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d = '0;
          hr_d  = (hr_q == 6'd23) ? 6'd0 : hr_q + 6'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    if (inc_ev && !alm_sel_eff) begin
      if (mode_q == S_SET_HOUR)     hr_d  = step(hr_q, 6'd23, dn);
      else if (mode_q == S_SET_MIN) min_d = step(min_q, 6'd59, dn);
    end

    // Entering a time edit restarts the current second from zero
    if (set_ev && mode_q == S_IDLE && !alm_sel_eff) begin
      sec_d = '0;
      pre_d = '0;
    end
  end

  always_comb begin
    hr_tens_d  = 2'(disp_hr / 6'd10);
    hr_ones_d  = 4'(disp_hr % 6'd10);
    min_tens_d = 3'(disp_min / 6'd10);
    min_ones_d = 4'(disp_min % 6'd10);
    led_k      = ((int'(sec_d) + 1) * LED_N) / 60;
    leds_d     = '0;
    for (int i = 0; i < LED_N; i++) leds_d[i] = (i < led_k);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q      <= '0;
      set_q      <= 1'b0;
      inc_q      <= 1'b0;
      mode_q     <= S_IDLE;
      hr_q       <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      hr_tens_q  <= '0;
      hr_ones_q  <= '0;
      min_tens_q <= '0;
      min_ones_q <= '0;
      leds_q     <= '0;
    end else begin
      pre_q      <= pre_d;
      set_q      <= set;
      inc_q      <= inc;
      mode_q     <= mode_d;
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      hr_tens_q  <= hr_tens_d;
      hr_ones_q  <= hr_ones_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      leds_q     <= leds_d;
    end
  end

`ifdef CLOCK_ALARM_EN
  logic [5:0] ahr_q, ahr_d, amin_q, amin_d, ring_q, ring_d;
  logic       alarm_q, alarm_d, match;

  assign alm_sel_eff = alm_sel;
  assign disp_hr     = (mode_d != S_IDLE && alm_sel) ? ahr_d  : hr_d;
  assign disp_min    = (mode_d != S_IDLE && alm_sel) ? amin_d : min_d;

  always_comb begin
    ahr_d   = ahr_q;
    amin_d  = amin_q;
    ring_d  = ring_q;
    alarm_d = alarm_q;
    if (inc_ev && alm_sel) begin
      if (mode_q == S_SET_HOUR)     ahr_d  = step(ahr_q, 6'd23, dn);
      else if (mode_q == S_SET_MIN) amin_d = step(amin_q, 6'd59, dn);
    end
    // A match wins over ack so a held ack still lets the ring show for one cycle
    match = tick && mode_q == S_IDLE && sec_q == 6'd59 && alm_en &&
            hr_d == ahr_q && min_d == amin_q;
    if (match) begin
      alarm_d = 1'b1;
      ring_d  = 6'(ALARM_LEN);
    end else if (ack || !alm_en) begin
      alarm_d = 1'b0;
      ring_d  = '0;
    end else if (tick && ring_q != 6'd0) begin
      ring_d  = ring_q - 6'd1;
      alarm_d = (ring_q != 6'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ahr_q   <= '0;
      amin_q  <= '0;
      ring_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      ahr_q   <= ahr_d;
      amin_q  <= amin_d;
      ring_q  <= ring_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_alm;
  assign unused_alm  = ^{alm_sel, alm_en, ack};
  assign alm_sel_eff = 1'b0;
  assign disp_hr     = hr_d;
  assign disp_min    = min_d;
  assign alarm       = 1'b0;
`endif

  assign hr_tens  = hr_tens_q;
  assign hr_ones  = hr_ones_q;
  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec      = sec_q;
  assign mode     = mode_q;
  assign leds     = leds_q;
endmodule

// File: tb/tb_clock_alarm_fsm.sv
// tb/tb_clock_alarm_fsm.sv - directed and random checks of clock_alarm_fsm against a seconds-of-day model
module tb_clock_alarm_fsm;
  localparam int TICK_DIV  = 4;
  localparam int LED_N     = 10;
  localparam int ALARM_LEN = 5;
`ifdef CLOCK_ALARM_EN
  localparam bit HAS_ALM = 1'b1;
`else
  localparam bit HAS_ALM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0, set = 1'b0, inc = 1'b0, dn = 1'b0;
  logic alm_sel = 1'b0, alm_en = 1'b0, ack = 1'b0;
  logic [1:0]       hr_tens;
  logic [3:0]       hr_ones;
  logic [2:0]       min_tens;
  logic [3:0]       min_ones;
  logic [5:0]       sec;
  logic [1:0]       mode;
  logic [LED_N-1:0] leds;
  logic             alarm;

  clock_alarm_fsm #(.TICK_DIV(TICK_DIV), .LED_N(LED_N), .ALARM_LEN(ALARM_LEN)) dut (
    .clk(clk), .rst(rst), .set(set), .inc(inc), .dn(dn), .alm_sel(alm_sel),
    .alm_en(alm_en), .ack(ack), .hr_tens(hr_tens), .hr_ones(hr_ones),
    .min_tens(min_tens), .min_ones(min_ones), .sec(sec), .mode(mode),
    .leds(leds), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: time as seconds of day, alarm as minutes of day
  int m_t = 0, m_am = 0, m_pre = 0, m_mode = 0, m_ring = 0;
  bit m_ring_on = 0, m_set_p = 0, m_inc_p = 0, m_disp_alm = 0;

  task automatic model_edge();
    bit sev, iev, tk, sel, rolled;
    int old_mode, d, mi;
    if (!rst) begin
      m_t = 0; m_am = 0; m_pre = 0; m_mode = 0; m_ring = 0;
      m_ring_on = 0; m_set_p = 0; m_inc_p = 0; m_disp_alm = 0;
      return;
    end
    sev = set && !m_set_p;
    iev = inc && !m_inc_p;
    m_set_p = set;
    m_inc_p = inc;
    sel = HAS_ALM && alm_sel;
    tk = (m_pre == TICK_DIV - 1);
    m_pre = tk ? 0 : m_pre + 1;
    old_mode = m_mode;
    m_mode = (m_mode + int'(sev)) % 3;
    rolled = 0;
    if (tk && (old_mode == 0 || sel)) begin
      m_t = (m_t + 1) % 86400;
      rolled = (m_t % 60 == 0);
    end
    if (iev && old_mode != 0) begin
      d = dn ? -1 : 1;
      if (sel) begin
        if (old_mode == 1) m_am = (m_am + d * 60 + 1440) % 1440;
        else m_am = (m_am / 60) * 60 + (m_am % 60 + d + 60) % 60;
      end else begin
        if (old_mode == 1) m_t = (m_t + d * 3600 + 86400) % 86400;
        else begin
          mi = (m_t / 60) % 60;
          m_t = m_t - mi * 60 + ((mi + d + 60) % 60) * 60;
        end
      end
    end
    if (sev && old_mode == 0 && !sel) begin
      m_t = m_t - m_t % 60;
      m_pre = 0;
    end
    if (HAS_ALM) begin
      if (rolled && old_mode == 0 && alm_en && m_t / 60 == m_am) begin
        m_ring = ALARM_LEN; m_ring_on = 1;
      end else if (ack || !alm_en) begin
        m_ring = 0; m_ring_on = 0;
      end else if (tk && m_ring > 0) begin
        m_ring--; m_ring_on = (m_ring > 0);
      end
    end
    m_disp_alm = (m_mode != 0) && sel;
  endtask

  function automatic logic [31:0] exp_vec();
    int shown, s, k;
    shown = m_disp_alm ? m_am : m_t / 60;
    s = m_t % 60;
    k = ((s + 1) * LED_N) / 60;
    return {2'(shown / 600), 4'((shown / 60) % 10), 3'((shown % 60) / 10), 4'(shown % 10),
            6'(s), 2'(m_mode), LED_N'((1 << k) - 1), 1'(HAS_ALM && m_ring_on)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("outputs", {hr_tens, hr_ones, min_tens, min_ones, sec, mode, leds, alarm}, exp_vec());
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic press_set();
    set = 1'b1; cyc(); set = 1'b0; cyc();
  endtask

  task automatic press_inc(input logic d);
    dn = d; inc = 1'b1; cyc(); inc = 1'b0; cyc();
  endtask

  initial begin
    rst = 1'b0;
    run(2);
    chk("rst_mode", mode, 0);
    chk("rst_sec", sec, 0);
    chk("rst_leds", leds, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_digits", {hr_tens, hr_ones, min_tens, min_ones}, 0);
    rst = 1'b1;

    run(236);
    chk("sec59", sec, 59);
    chk("leds_full", leds, 10'h3FF);
    run(4);
    chk("min1", {hr_tens, hr_ones, min_tens, min_ones}, 1);
    chk("min1_sec", sec, 0);
    chk("leds_clear", leds, 0);

    press_set();
    chk("set_mode", mode, 1);
    press_inc(1'b1);
    chk("hr_dn_wrap", {hr_tens, hr_ones}, 8'h23);
    press_inc(1'b0);
    chk("hr_up_wrap", {hr_tens, hr_ones}, 0);
    press_inc(1'b1);
    run(40);
    chk("frozen_sec", sec, 0);
    chk("frozen_min", {min_tens, min_ones}, 8'h01);

    press_set();
    chk("min_mode", mode, 2);
    press_inc(1'b1);
    press_inc(1'b1);
    chk("min_dn_wrap", {min_tens, min_ones}, 8'h59);
    chk("min_hr_kept", {hr_tens, hr_ones}, 8'h23);
    dn = 1'b1; inc = 1'b1; run(100); inc = 1'b0; run(2);
    chk("held_inc", {min_tens, min_ones}, 8'h58);
    press_inc(1'b0);
    press_set();
    chk("idle_mode", mode, 0);

    for (int i = 0; i < 400 && m_t != 86398; i++) cyc();
    chk("pre_roll", {hr_tens, hr_ones, min_tens, min_ones, sec}, {6'h23, 7'h59, 6'd58});
    run(2 * TICK_DIV);
    chk("rollover", {hr_tens, hr_ones, min_tens, min_ones, sec}, 0);

    for (int i = 0; i < 400 && !(m_t == 59 && m_pre == TICK_DIV - 1); i++) cyc();
    chk("pre_sim_sec", sec, 59);
    set = 1'b1; cyc(); set = 1'b0;
    chk("sim_time", {hr_tens, hr_ones, min_tens, min_ones, sec}, {6'h00, 7'h01, 6'd0});
    chk("sim_mode", mode, 1);
    press_set();
    rst = 1'b0; cyc();
    chk("rst_mid", {hr_tens, hr_ones, min_tens, min_ones, sec, mode, leds, alarm}, 0);
    rst = 1'b1;

    alm_en = 1'b1; alm_sel = 1'b1;
    press_set(); press_set(); press_inc(1'b0); press_inc(1'b0);
    chk("alm_disp", {min_tens, min_ones}, 8'h02);
    press_set(); alm_sel = 1'b0;
    for (int i = 0; i < 800 && m_t != 120; i++) cyc();
    chk("alm_rise", alarm, HAS_ALM);
    chk("alm_time", {min_tens, min_ones, sec}, {7'h02, 6'd0});
    run(ALARM_LEN * TICK_DIV - 1);
    chk("alm_hold", alarm, HAS_ALM);
    cyc();
    chk("alm_fall", alarm, 0);

    alm_sel = 1'b1;
    press_set(); press_set(); press_inc(1'b0); press_set(); alm_sel = 1'b0;
    for (int i = 0; i < 800 && m_t != 180; i++) cyc();
    chk("alm2_rise", alarm, HAS_ALM);
    run(3 * TICK_DIV);
    chk("alm2_ring", alarm, HAS_ALM);
    ack = 1'b1; cyc(); ack = 1'b0;
    chk("ack_drop", alarm, 0);
    run(2 * TICK_DIV);
    chk("ack_stays", alarm, 0);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 19) == 0) set = ~set;
      if ($urandom_range(0, 9) == 0) inc = ~inc;
      dn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) alm_sel = ~alm_sel;
      alm_en = ($urandom_range(0, 99) != 0);
      ack    = ($urandom_range(0, 199) == 0);
      rst    = ($urandom_range(0, 999) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_alarm_fsm.md
# clock_alarm_fsm

Parametrised digital clock core with an independent alarm. It keeps HH:MM:SS time in BCD from a prescaled system clock and lets the user set time or alarm hours and minutes, up or down, through a set/inc button FSM. It drives a configurable seconds-progress LED bar and a timed alarm output. It sits between the board button inputs and the external 7-segment digit decoders, which consume its BCD digit outputs directly.

## Interface
- `TICK_DIV`, 50_000_000: `clk` cycles per second; minimum 2.
- `LED_N`, 10: width of the seconds-progress bar; 1..60.
- `ALARM_LEN`, 30: seconds the alarm output stays high if it is not acknowledged; 1..63.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `set`  in  1  mode button, level, already synchronised; its rising edge advances the FSM.
- `inc`  in  1  adjust button, level; its rising edge adjusts the selected field.
- `dn`  in  1  0 = increment, 1 = decrement for `inc` adjustments.
- `alm_sel`  in  1  0 = adjust time registers, 1 = adjust alarm registers.
- `alm_en`  in  1  arms alarm matching.
- `ack`  in  1  level; clears a ringing alarm.
- `hr_tens`  out  2  hours tens digit, BCD, shows time or alarm per `alm_sel` while in a SET state.
- `hr_ones`  out  4  hours ones digit, BCD.
- `min_tens`  out  3  minutes tens digit, BCD.
- `min_ones`  out  4  minutes ones digit, BCD.
- `sec`  out  6  seconds, binary 0..59, always the time value.
- `mode`  out  2  FSM state: 00 IDLE, 01 SET_HOUR, 10 SET_MINUTE.
- `leds`  out  LED_N  seconds thermometer bar.
- `alarm`  out  1  alarm ringing.

## Operation
- Prescaler `pre` counts 0..TICK_DIV-1. `tick` is asserted when `pre == TICK_DIV-1`; `pre` then wraps to 0.
- Edge detect: registered copies `set_q` and `inc_q`. An event is `x & ~x_q`. A button held high produces exactly one event.
- FSM (state register = `mode`): IDLE -set-> SET_HOUR -set-> SET_MINUTE -set-> IDLE. Encoding 11 is illegal and recovers to IDLE on the next cycle.
- Timekeeping runs on `tick`:
  - It is frozen while `mode != IDLE` and `alm_sel == 0` (time is being edited).
  - It runs in every other case, including while alarm registers are edited.
  - Order: sec 59->0 carries to minutes; 59->00 carries to hours; 23->00 wraps.
- On entering SET_HOUR with `alm_sel == 0`, `sec` and `pre` clear to 0.
- `inc` event in SET_HOUR adjusts the hours of the selected register set:
  - `dn=0`: +1, 23 -> 00.
  - `dn=1`: -1, 00 -> 23, x0 -> (x-1)9.
- `inc` event in SET_MINUTE adjusts the minutes of the selected set the same way: 59 -> 00 up, 00 -> 59 down. There is no carry into hours.
- `inc` events in IDLE are ignored.
- Digit outputs show the alarm registers when `mode != IDLE` and `alm_sel == 1`; otherwise they show the time.
- `leds`: k = ((sec+1)*LED_N)/60; bits [k-1:0] are 1, the rest 0. `sec == 59` lights all bits.
- Alarm match:
  - Condition: a tick rolls sec 59->0 in IDLE, `alm_en == 1`, and the new HH:MM equals the alarm HH:MM.
  - Effect: `alarm` rises and the ring counter loads ALARM_LEN.
  - The counter decrements each tick; `alarm` drops when it reaches 0, or on the cycle after `ack == 1`, or when `alm_en` falls.

## Timing
- Reset (`rst == 0` at a clk edge) clears, on that edge:
  - time 00:00:00 and alarm 00:00;
  - `pre`, `set_q`, `inc_q`;
  - `mode` = IDLE, `leds` = 0, `alarm` = 0, ring counter = 0.
- Reset mid-operation overrides every other event that cycle.
- Button event latency: the edge is sampled at clk edge N, and the register update is visible after edge N (one cycle).
- `tick` and a `set` event in the same cycle: the tick is applied using the current state, and the state changes simultaneously. A tick in IDLE is not lost.
- `tick` and an `inc` event in the same cycle while editing alarm registers: both are applied, to independent registers.
- `leds`, `alarm` and the digits are registered outputs that update one cycle after the causing event.
- `ack` held high across a match suppresses the ring: `alarm` is asserted for at most one cycle.

## Configuration
- `CLOCK_ALARM_EN` defined:
  - Alarm registers, match logic and ring counter are present.
  - `alm_sel`, `alm_en` and `ack` are functional.
- `CLOCK_ALARM_EN` undefined:
  - Alarm logic is not compiled.
  - `alarm` is tied to 0.
  - `alm_sel`, `alm_en` and `ack` are ignored; `alm_sel` behaves as 0.
  - Ports remain, so the interface is unchanged.

## Test plan
- Reset then free run, TICK_DIV=4: after 4*60 cycles, digits read 00:01 and `sec`=0. `leds` reach all-ones at sec 59 and clear at sec 0.
- Rollover: preload 23:59:58, run 2 ticks -> 00:00:00, with no glitch on `hr_tens`.
- Set mode: 1x `set`, then `inc` with `dn=1` at 00 -> 23, `inc` with `dn=0` -> 00. `sec` stays 0 and frozen throughout.
- Minute edit: SET_MINUTE at 00, `dn=1` `inc` -> 59 with hours unchanged. A held `inc` for 100 cycles gives exactly one step.
- Alarm: alarm set to 00:02 with `alm_en=1`; `alarm` rises on the tick to 00:02:00 and falls ALARM_LEN ticks later. A repeat with `ack` pulsed 3 ticks in drops `alarm` the next cycle.
- Simultaneous events: a `set` event on a tick cycle at 00:00:59 gives 00:01:00 together with `mode`=SET_HOUR. `rst=0` during SET_MINUTE gives IDLE and all zeros at the next edge.
